vx_iter_divider_unit: RTL and testbench
=======================================

// Module: vx_iter_divider_unit
// PURPOSE
//  Multi-lane iterative integer divider/remainder unit for the ALU M-extension path.
//  Computes one quotient bit per lane per cycle (radix-2, non-restoring on magnitudes).
//  Supports RV signed/unsigned DIV/REM, an XLEN-64 32-bit "W" mode, and an early-out path.
//  Passes a caller tag and thread mask through; uses a valid/ready handshake on both sides.
// PARAMETERS
//  XLEN      32  operand/result width per lane (32 or 64)
//  LANES     4   SIMD lanes processed in lockstep
//  TAG_W     8   width of opaque tag carried from request to response
//  W_MODE    0   1 = honour is_w (legal only with XLEN=64); 0 = is_w ignored
// PORTS
//  clk        in   1             clock
//  reset      in   1             asynchronous, active-high reset
//  valid_in   in   1             request valid
//  ready_in   out  1             unit can accept a request
//  is_signed  in   1             signed DIV/REM
//  is_rem     in   1             1 = return remainder, 0 = quotient
//  is_w       in   1             32-bit op: use [31:0], sign-extend result
//  tmask_in   in   LANES         active-lane mask
//  tag_in     in   TAG_W         opaque tag
//  numer      in   LANES*XLEN    dividends, lane i at [i*XLEN +: XLEN]
//  denom      in   LANES*XLEN    divisors, same packing
//  valid_out  out  1             response valid
//  ready_out  in   1             consumer accepts response
//  result     out  LANES*XLEN    per-lane quotient or remainder
//  tmask_out  out  LANES         captured tmask_in
//  tag_out    out  TAG_W         captured tag_in
//  busy       out  1             state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, valid_out=0, busy=0, iteration counter=0.
//   Datapath, tag and result registers are not reset.
//   Reset mid-operation abandons the op; no response is produced.
//  FSM: IDLE -> CALC -> FIX -> DONE.
//   IDLE: ready_in=1. On fire, capture operands, mode, tag and mask, then go to CALC.
//    If every active lane has denom==0 or numer==0 (or tmask_in==0), go to FIX directly.
//   CALC: N iterations, N = 32 if (W_MODE && is_w) else XLEN. Counter counts N-1..0.
//    Exit to FIX when the counter reaches 0.
//   FIX: one cycle; apply sign correction and the special cases below; go to DONE.
//   DONE: valid_out=1 and all outputs are held stable until ready_out.
//    ready_in = ready_out in DONE.
//    Fire on both sides in the same cycle: go to CALC/FIX with the new op; valid_out drops.
//    ready_out alone: go to IDLE.
//  Latency, accept to valid_out: N+2 cycles (normal path), 2 cycles (early-out path).
//  Throughput: 1 op per N+2 cycles, with zero dead cycles when back-to-back.
//  Operand prep: W mode uses bits [31:0], sign-extended if is_signed, else zero-extended.
//   Signed ops divide magnitudes; the result is negated if required:
//   quotient sign = sn^sd, remainder sign = sn.
//  Special cases, per lane, in FIX:
//   denom==0: quotient = all-ones (-1), remainder = numer.
//   Signed MIN/-1: quotient = MIN, remainder = 0 (natural result of the magnitude path).
//   Inactive lane: result = 0.
//  W mode: the 32-bit result is sign-extended to XLEN, for both signed and unsigned ops.
//  valid_in while ready_in=0 is ignored. Inputs are sampled only on fire.
// TESTING
//  1 XLEN=32, unsigned 100/7, is_rem=0, all lanes:
//    result=14 each; valid_out exactly 34 cycles after fire.
//  2 Signed -7/2: quotient=-3 (0xFFFFFFFD); is_rem=1: remainder=-1 (0xFFFFFFFF).
//    Signed 0x80000000/-1: quotient=0x80000000, remainder=0.
//  3 denom=0, numer=-5 signed, on every lane:
//    early-out path; valid_out 2 cycles after fire; quotient=0xFFFFFFFF, rem=0xFFFFFFFB.
//  4 tmask=4'b0101, lane1 denom=0, lanes 0/2 normal:
//    no early-out; lanes 1/3 result=0; tag_out==tag_in.
//  5 ready_out held low 10 cycles in DONE, then raised together with a new valid_in:
//    outputs stable throughout; new op accepted on the same edge; 2nd result after N+2.
//  6 XLEN=64, W_MODE=1, is_w=1, signed 0x00000000_FFFFFFF8 / 2:
//    32 iterations; result=0xFFFFFFFF_FFFFFFFC.
//    Assert reset during CALC: valid_out=0, busy=0 immediately.

Source files
------------

// File: rtl/vx_iter_divider_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vx_iter_divider_unit                                            |
// | Purpose  : Multi-lane radix-2 iterative DIV/REM unit with early-out path   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vx_iter_divider_unit #(
    parameter int XLEN   = 32,
    parameter int LANES  = 4,
    parameter int TAG_W  = 8,
    parameter int W_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic                  is_signed,
    input  logic                  is_rem,
    input  logic                  is_w,
    input  logic [LANES-1:0]      tmask_in,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic [LANES*XLEN-1:0] numer,
    input  logic [LANES*XLEN-1:0] denom,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [LANES*XLEN-1:0] result,
    output logic [LANES-1:0]      tmask_out,
    output logic [TAG_W-1:0]      tag_out,
    output logic                  busy
);

    localparam int c_RW = XLEN + 2;
    localparam int c_CW = $clog2(XLEN);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;
    localparam logic [c_CW-1:0] c_N_FULL = c_CW'(XLEN - 1);
    localparam logic [c_CW-1:0] c_N_W    = c_CW'(31);

    // Re-extend bits [31:0] of v to XLEN, sign- or zero-filling the top.
    function automatic logic [XLEN-1:0] f_ext32(input logic [XLEN-1:0] v, input logic sx);
        logic [XLEN-1:0] t;
        t = v << (XLEN - 32);
        if (sx) f_ext32 = $signed(t) >>> (XLEN - 32);
        else    f_ext32 = t >> (XLEN - 32);
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_nx;
    logic             w_fire;
    logic             w_wop;
    logic             w_early;
    logic [LANES-1:0] w_trivial;
    logic             r_is_rem;
    logic             r_w;
    logic [LANES-1:0] r_tmask;
    logic [TAG_W-1:0] r_tag;

    assign w_wop     = (W_MODE != 0) && is_w;
    assign ready_in  = (r_state == c_IDLE) || ((r_state == c_DONE) && ready_out);
    assign w_fire    = valid_in && ready_in;
    assign w_early   = &w_trivial;
    assign valid_out = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign tmask_out = r_tmask;
    assign tag_out   = r_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            c_CALC: begin
                if (r_cnt == '0) w_state_nx = c_FIX;
                else             w_cnt_nx   = r_cnt - c_CW'(1);
            end
            c_FIX:   w_state_nx = c_DONE;
            c_DONE:  if (ready_out) w_state_nx = c_IDLE;
            default: ;
        endcase
        // A new op may be accepted from IDLE or straight out of DONE.
        if (w_fire) begin
            w_state_nx = w_early ? c_FIX : c_CALC;
            w_cnt_nx   = w_wop ? c_N_W : c_N_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_is_rem <= is_rem;
            r_w      <= w_wop;
            r_tmask  <= tmask_in;
            r_tag    <= tag_in;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [XLEN-1:0] w_n_raw, w_d_raw, w_n_ext, w_d_ext, w_n_mag, w_d_mag;
        logic            w_sn, w_sd;
        logic [c_RW-1:0] w_sh_rem, w_step;
        logic [XLEN-1:0] w_quo_nx, w_rmag, w_quo_s, w_rem_s, w_sel, w_res;
        logic [c_RW-1:0] r_rem;
        logic [XLEN-1:0] r_quo, r_div, r_num, r_res;
        logic            r_nq, r_nr, r_dz;

        assign w_n_raw = numer[gi*XLEN +: XLEN];
        assign w_d_raw = denom[gi*XLEN +: XLEN];
        assign w_n_ext = w_wop ? f_ext32(w_n_raw, is_signed) : w_n_raw;
        assign w_d_ext = w_wop ? f_ext32(w_d_raw, is_signed) : w_d_raw;
        assign w_sn    = is_signed & w_n_ext[XLEN-1];
        assign w_sd    = is_signed & w_d_ext[XLEN-1];
        assign w_n_mag = w_sn ? -w_n_ext : w_n_ext;
        assign w_d_mag = w_sd ? -w_d_ext : w_d_ext;
        assign w_trivial[gi] = !tmask_in[gi] || (w_d_ext == '0) || (w_n_ext == '0);

        // Non-restoring step: quotient bits match restoring, only the remainder needs a fixup.
        assign w_sh_rem = {r_rem[XLEN:0], r_quo[XLEN-1]};
        assign w_step   = r_rem[c_RW-1] ? (w_sh_rem + {2'b00, r_div}) : (w_sh_rem - {2'b00, r_div});
        assign w_quo_nx = {r_quo[XLEN-2:0], ~w_step[c_RW-1]};

        assign w_rmag  = r_rem[c_RW-1] ? (r_rem[XLEN-1:0] + r_div) : r_rem[XLEN-1:0];
        assign w_quo_s = r_dz ? '1    : (r_nq ? -r_quo  : r_quo);
        assign w_rem_s = r_dz ? r_num : (r_nr ? -w_rmag : w_rmag);
        assign w_sel   = r_is_rem ? w_rem_s : w_quo_s;
        assign w_res   = !r_tmask[gi] ? '0 : (r_w ? f_ext32(w_sel, 1'b1) : w_sel);

        always_ff @(posedge clk) begin
            if (w_fire) begin
                r_rem <= '0;
                // W ops run 32 iterations, so the dividend starts at the top of the shifter.
                r_quo <= w_wop ? (w_n_mag << (XLEN - 32)) : w_n_mag;
                r_div <= w_d_mag;
                r_nq  <= w_sn ^ w_sd;
                r_nr  <= w_sn;
                r_dz  <= (w_d_ext == '0);
                r_num <= w_n_ext;
            end else if (r_state == c_CALC) begin
                r_rem <= w_step;
                r_quo <= w_quo_nx;
            end
            if (r_state == c_FIX) r_res <= w_res;
        end

        assign result[gi*XLEN +: XLEN] = r_res;
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_iter_divider_unit.sv
`default_nettype none
// Directed bench for vx_iter_divider_unit: a 32-bit instance and a 64-bit W-mode instance.
module tb_vx_iter_divider_unit;
    localparam int LN = 4;
    localparam int TW = 8;
    localparam int XA = 32;
    localparam int XB = 64;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic             a_rst, a_vin, a_rdy_in, a_sgn, a_rem, a_w, a_vout, a_rout, a_busy;
    logic [LN-1:0]    a_tm, a_tmo;
    logic [TW-1:0]    a_tag, a_tago;
    logic [LN*XA-1:0] a_num, a_den, a_res;

    logic             b_rst, b_vin, b_rdy_in, b_sgn, b_rem, b_w, b_vout, b_rout, b_busy;
    logic [LN-1:0]    b_tm, b_tmo;
    logic [TW-1:0]    b_tag, b_tago;
    logic [LN*XB-1:0] b_num, b_den, b_res;

    vx_iter_divider_unit #(.XLEN(XA), .LANES(LN), .TAG_W(TW), .W_MODE(0)) dut_a (
        .clk(clk), .reset(a_rst), .valid_in(a_vin), .ready_in(a_rdy_in),
        .is_signed(a_sgn), .is_rem(a_rem), .is_w(a_w), .tmask_in(a_tm), .tag_in(a_tag),
        .numer(a_num), .denom(a_den), .valid_out(a_vout), .ready_out(a_rout),
        .result(a_res), .tmask_out(a_tmo), .tag_out(a_tago), .busy(a_busy)
    );

    vx_iter_divider_unit #(.XLEN(XB), .LANES(LN), .TAG_W(TW), .W_MODE(1)) dut_b (
        .clk(clk), .reset(b_rst), .valid_in(b_vin), .ready_in(b_rdy_in),
        .is_signed(b_sgn), .is_rem(b_rem), .is_w(b_w), .tmask_in(b_tm), .tag_in(b_tag),
        .numer(b_num), .denom(b_den), .valid_out(b_vout), .ready_out(b_rout),
        .result(b_res), .tmask_out(b_tmo), .tag_out(b_tago), .busy(b_busy)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic a_issue(input logic sgn, input logic rem, input logic w, input logic [LN-1:0] tm,
                           input logic [TW-1:0] tag, input logic [LN*XA-1:0] n, input logic [LN*XA-1:0] d);
        a_sgn = sgn; a_rem = rem; a_w = w; a_tm = tm; a_tag = tag; a_num = n; a_den = d;
        a_vin = 1'b1;
        @(posedge clk); #1;
        a_vin = 1'b0;
    endtask

    task automatic a_wait(output int cyc);
        cyc = 1;
        while (a_vout !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic b_issue(input logic sgn, input logic rem, input logic w, input logic [LN-1:0] tm,
                           input logic [TW-1:0] tag, input logic [LN*XB-1:0] n, input logic [LN*XB-1:0] d);
        b_sgn = sgn; b_rem = rem; b_w = w; b_tm = tm; b_tag = tag; b_num = n; b_den = d;
        b_vin = 1'b1;
        @(posedge clk); #1;
        b_vin = 1'b0;
    endtask

    task automatic b_wait(output int cyc);
        cyc = 1;
        while (b_vout !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b0; b_rst = 1'b0;
        a_vin = 1'b0; b_vin = 1'b0; a_rout = 1'b1; b_rout = 1'b1;
        a_sgn = 0; a_rem = 0; a_w = 0; a_tm = '0; a_tag = '0; a_num = '0; a_den = '0;
        b_sgn = 0; b_rem = 0; b_w = 0; b_tm = '0; b_tag = '0; b_num = '0; b_den = '0;
        @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;
        #1;
        n_cmp++; if (a_vout !== 1'b0) begin n_bad++; $display("FAIL reset_valid_a: got %b want 0", a_vout); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a: got %b want 0", a_busy); end
        n_cmp++; if (a_rdy_in !== 1'b1) begin n_bad++; $display("FAIL reset_ready_a: got %b want 1", a_rdy_in); end
        n_cmp++; if (b_vout !== 1'b0 || b_busy !== 1'b0) begin n_bad++; $display("FAIL reset_b: got v=%b busy=%b want 0/0", b_vout, b_busy); end
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (a_busy !== 1'b0 || a_rdy_in !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle: got busy=%b rdy=%b want 0/1", a_busy, a_rdy_in); end
    endtask

    task automatic test_unsigned();
        int cyc;
        a_issue(1'b0, 1'b0, 1'b0, 4'hF, 8'h01, {4{32'd100}}, {4{32'd7}});
        n_cmp++; if (a_busy !== 1'b1 || a_rdy_in !== 1'b0) begin n_bad++; $display("FAIL udiv_busy: got busy=%b rdy=%b want 1/0", a_busy, a_rdy_in); end
        a_wait(cyc);
        n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL udiv_latency: got %0d want 34", cyc); end
        n_cmp++; if (a_res !== {4{32'd14}}) begin n_bad++; $display("FAIL udiv_result: got %h want %h", a_res, {4{32'd14}}); end
        @(posedge clk); #1;
        n_cmp++; if (a_vout !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL udiv_drain: got v=%b busy=%b want 0/0", a_vout, a_busy); end
        // is_w must be ignored on a W_MODE=0 instance
        a_issue(1'b0, 1'b1, 1'b1, 4'hF, 8'h02, {32'd100, 32'd255, 32'hFFFFFFFF, 32'd100}, {32'd7, 32'd16, 32'd10, 32'd200});
        a_wait(cyc);
        n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL urem_latency: got %0d want 34", cyc); end
        n_cmp++; if (a_res !== {32'd2, 32'd15, 32'd5, 32'd100}) begin n_bad++; $display("FAIL urem_result: got %h want %h", a_res, {32'd2, 32'd15, 32'd5, 32'd100}); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        int cyc;
        logic [LN*XA-1:0] n, d;
        n = {32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9};
        d = {32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2};
        a_issue(1'b1, 1'b0, 1'b0, 4'hF, 8'h03, n, d);
        a_wait(cyc);
        n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL sdiv_latency: got %0d want 34", cyc); end
        n_cmp++; if (a_res !== {32'd3, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD}) begin n_bad++; $display("FAIL sdiv_result: got %h want %h", a_res, {32'd3, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD}); end
        @(posedge clk); #1;
        a_issue(1'b1, 1'b1, 1'b0, 4'hF, 8'h04, n, d);
        a_wait(cyc);
        n_cmp++; if (a_res !== {32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF}) begin n_bad++; $display("FAIL srem_result: got %h want %h", a_res, {32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF}); end
        @(posedge clk); #1;
    endtask

    task automatic test_early_out();
        int cyc;
        a_issue(1'b1, 1'b0, 1'b0, 4'hF, 8'h05, {4{32'hFFFFFFFB}}, {4{32'd0}});
        a_wait(cyc);
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL dz_div_latency: got %0d want 2", cyc); end
        n_cmp++; if (a_res !== {4{32'hFFFFFFFF}}) begin n_bad++; $display("FAIL dz_div_result: got %h want %h", a_res, {4{32'hFFFFFFFF}}); end
        @(posedge clk); #1;
        a_issue(1'b1, 1'b1, 1'b0, 4'hF, 8'h06, {4{32'hFFFFFFFB}}, {4{32'd0}});
        a_wait(cyc);
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL dz_rem_latency: got %0d want 2", cyc); end
        n_cmp++; if (a_res !== {4{32'hFFFFFFFB}}) begin n_bad++; $display("FAIL dz_rem_result: got %h want %h", a_res, {4{32'hFFFFFFFB}}); end
        @(posedge clk); #1;
        a_issue(1'b0, 1'b0, 1'b0, 4'h0, 8'h07, {4{32'd50}}, {4{32'd5}});
        a_wait(cyc);
        n_cmp++; if (cyc !== 2 || a_res !== '0 || a_tmo !== 4'h0) begin n_bad++; $display("FAIL nomask: got lat=%0d res=%h tm=%h want 2/0/0", cyc, a_res, a_tmo); end
        @(posedge clk); #1;
        a_issue(1'b0, 1'b0, 1'b0, 4'hF, 8'h08, {4{32'd0}}, {4{32'd3}});
        a_wait(cyc);
        n_cmp++; if (cyc !== 2 || a_res !== '0) begin n_bad++; $display("FAIL zero_numer: got lat=%0d res=%h want 2/0", cyc, a_res); end
        @(posedge clk); #1;
    endtask

    task automatic test_masked_lanes();
        int cyc;
        a_issue(1'b1, 1'b0, 1'b0, 4'b0101, 8'hA5,
                {32'd50, 32'hFFFFFFF7, 32'd5, 32'd100}, {32'd5, 32'd4, 32'd0, 32'd7});
        a_wait(cyc);
        n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL mask_latency: got %0d want 34", cyc); end
        n_cmp++; if (a_res !== {32'd0, 32'hFFFFFFFE, 32'd0, 32'd14}) begin n_bad++; $display("FAIL mask_result: got %h want %h", a_res, {32'd0, 32'hFFFFFFFE, 32'd0, 32'd14}); end
        n_cmp++; if (a_tago !== 8'hA5 || a_tmo !== 4'b0101) begin n_bad++; $display("FAIL mask_tag: got tag=%h tm=%b want a5/0101", a_tago, a_tmo); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad_hold;
        a_rout = 1'b0;
        a_issue(1'b0, 1'b0, 1'b0, 4'hF, 8'h11, {4{32'd1000}}, {4{32'd10}});
        a_wait(cyc);
        n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 34", cyc); end
        bad_hold = 0;
        for (int k = 0; k < 10; k++) begin
            if (a_vout !== 1'b1 || a_rdy_in !== 1'b0 || a_res !== {4{32'd100}} || a_tago !== 8'h11 || a_tmo !== 4'hF)
                bad_hold++;
            @(posedge clk); #1;
        end
        n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL b2b_hold: got %0d unstable cycles want 0", bad_hold); end
        a_rout = 1'b1;
        a_sgn = 1'b0; a_rem = 1'b0; a_w = 1'b0; a_tm = 4'hF; a_tag = 8'h22;
        a_num = {4{32'd77}}; a_den = {4{32'd7}};
        a_vin = 1'b1;
        #1;
        n_cmp++; if (a_rdy_in !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", a_rdy_in); end
        @(posedge clk); #1;
        a_vin = 1'b0;
        n_cmp++; if (a_vout !== 1'b0 || a_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got v=%b busy=%b want 0/1", a_vout, a_busy); end
        a_wait(cyc);
        n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 34", cyc); end
        n_cmp++; if (a_res !== {4{32'd11}} || a_tago !== 8'h22) begin n_bad++; $display("FAIL b2b_second_result: got %h tag=%h want %h tag=22", a_res, a_tago, {4{32'd11}}); end
        @(posedge clk); #1;
    endtask

    task automatic test_w_mode();
        int cyc;
        b_issue(1'b1, 1'b0, 1'b1, 4'hF, 8'h33,
                {64'h12345678_80000000, 64'hDEADBEEF_FFFFFFF9, 64'h00000000_00000064, 64'h00000000_FFFFFFF8},
                {64'hFFFFFFFF_FFFFFFFF, 64'hFFFF0000_00000002, 64'h00000000_00000007, 64'h00000000_00000002});
        b_wait(cyc);
        n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL w_latency: got %0d want 34", cyc); end
        n_cmp++; if (b_res !== {64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFFD, 64'd14, 64'hFFFFFFFF_FFFFFFFC}) begin
            n_bad++; $display("FAIL w_result: got %h want %h", b_res, {64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFFD, 64'd14, 64'hFFFFFFFF_FFFFFFFC}); end
        @(posedge clk); #1;
        b_issue(1'b1, 1'b0, 1'b0, 4'hF, 8'h34,
                {64'd1000, 64'd1000, 64'd1000, 64'hFFFFFFFF_FFFFFC18}, {4{64'd10}});
        b_wait(cyc);
        n_cmp++; if (cyc !== 66) begin n_bad++; $display("FAIL x64_latency: got %0d want 66", cyc); end
        n_cmp++; if (b_res !== {64'd100, 64'd100, 64'd100, 64'hFFFFFFFF_FFFFFF9C}) begin
            n_bad++; $display("FAIL x64_result: got %h want %h", b_res, {64'd100, 64'd100, 64'd100, 64'hFFFFFFFF_FFFFFF9C}); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        b_issue(1'b0, 1'b0, 1'b0, 4'hF, 8'h44, {4{64'd500}}, {4{64'd3}});
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (b_busy !== 1'b1 || b_vout !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got busy=%b v=%b want 1/0", b_busy, b_vout); end
        b_rst = 1'b1;
        #1;
        n_cmp++; if (b_vout !== 1'b0 || b_busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset: got v=%b busy=%b want 0/0", b_vout, b_busy); end
        #1;
        b_rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (b_vout === 1'b1 || b_busy !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_abandon: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_early_out();
        test_masked_lanes();
        test_back_to_back();
        test_w_mode();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
